// File: rtl/defuzz_serial_pkg.sv
// Shared widths, FSM encoding and sign helper for the serial Sugeno defuzzifier.
package defuzz_serial_pkg;

  localparam int N_RULES   = 9;
  localparam int W_W       = 16;
  localparam int C_W       = 16;
  localparam int NUM_W     = 36;
  localparam int DEN_W     = 20;
  localparam int DIV_STEPS = 35;
  localparam int MAG_W     = NUM_W - 1;  // |num_acc| magnitude bits
  localparam int Q_W       = C_W + 1;    // quotient bits the parent consumes (up to 32768)
  localparam int K_W       = 4;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DIV   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Two's-complement sign application; a magnitude of 32768 maps to -32768 only.
  function automatic logic [C_W-1:0] apply_sign(input logic [Q_W-1:0] mag, input logic neg);
    return C_W'(neg ? (~mag + 1'b1) : mag);
  endfunction

endpackage

// File: rtl/defuzz_serial_div.sv
// Unsigned restoring divider: 35-bit dividend by 20-bit divisor, one quotient bit per cycle.
// The load cycle also performs the first step, so done_o rises 35 cycles after start_i.
module defuzz_serial_div
  import defuzz_serial_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [MAG_W-1:0] dividend_i,
  input  logic [DEN_W-1:0] divisor_i,
  output logic [Q_W-1:0]   quotient_o,
  output logic             done_o
);

  logic [MAG_W-1:0] dvd_q, dvd_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [MAG_W-1:0] src_dvd;
  logic [DEN_W-1:0] src_rem;
  logic [DEN_W-1:0] src_den;
  logic [DEN_W:0]   shifted;
  logic             ge;

  // NOTE: every variable is given a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    src_dvd = start_i ? dividend_i : dvd_q;
    src_rem = start_i ? '0 : rem_q;
    src_den = start_i ? divisor_i : den_q;
    shifted = {src_rem, src_dvd[MAG_W-1]};
    ge      = shifted >= {1'b0, src_den};

    dvd_d  = dvd_q;
    rem_d  = rem_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start_i || busy_q) begin
      // Quotient bits enter at the LSB as dividend bits leave the MSB.
      rem_d = ge ? DEN_W'(shifted - {1'b0, src_den}) : shifted[DEN_W-1:0];
      dvd_d = {src_dvd[MAG_W-2:0], ge};
      den_d = src_den;
      if (start_i) begin
        cnt_d  = CNT_W'(1);
        busy_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded by start_i before being read.
  always_ff @(posedge clk) begin
    dvd_q <= dvd_d;
    rem_q <= rem_d;
    den_q <= den_d;
  end

  assign quotient_o = dvd_q[Q_W-1:0];
  assign done_o     = done_q;

endmodule

// File: rtl/defuzz_serial.sv
// Zero-order Sugeno defuzzifier: y = sum(w_k*c_k)/sum(w_k) with one MAC per cycle
// followed by a serial restoring divide; sign is applied here, magnitude comes from the divider.
module defuzz_serial
  import defuzz_serial_pkg::*;
#(
  parameter logic signed [15:0] DEFAULT_Y = 16'sd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         w00,
  input  logic [15:0]         w01,
  input  logic [15:0]         w02,
  input  logic [15:0]         w10,
  input  logic [15:0]         w11,
  input  logic [15:0]         w12,
  input  logic [15:0]         w20,
  input  logic [15:0]         w21,
  input  logic [15:0]         w22,
  input  logic [143:0]        c_all,
  output logic signed [15:0]  y,
  output logic                out_valid,
  output logic                busy,
  output logic                zero_w
);

  state_e                  state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [K_W-1:0]          k_idx;
  logic signed [NUM_W-1:0] num_acc_q, num_acc_d;
  logic [DEN_W-1:0]        den_acc_q, den_acc_d;
  logic signed [C_W-1:0]   y_q, y_d;
  logic                    zero_w_q, zero_w_d;
  logic                    load;

  logic [W_W-1:0]          w_in [N_RULES];
  logic [W_W-1:0]          w_q  [N_RULES];
  logic signed [C_W-1:0]   c_q  [N_RULES];
  logic signed [W_W+C_W:0] prod;

  logic                    div_start;
  logic                    div_done;
  logic [MAG_W-1:0]        num_mag;
  logic [Q_W-1:0]          div_quot;

  assign w_in = '{w00, w01, w02, w10, w11, w12, w20, w21, w22};

  assign k_idx   = (k_q < K_W'(N_RULES)) ? k_q : '0;
  assign prod    = $signed({1'b0, w_q[k_idx]}) * c_q[k_idx];
  assign num_mag = num_acc_q[NUM_W-1] ? MAG_W'(-num_acc_q) : num_acc_q[MAG_W-1:0];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    num_acc_d = num_acc_q;
    den_acc_d = den_acc_q;
    y_d       = y_q;
    zero_w_d  = zero_w_q;
    load      = 1'b0;
    div_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          num_acc_d = '0;
          den_acc_d = '0;
          k_d       = '0;
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // Nine MAC cycles, then one cycle that inspects the finished sums.
        if (k_q != K_W'(N_RULES)) begin
          num_acc_d = num_acc_q + NUM_W'(prod);
          den_acc_d = den_acc_q + DEN_W'(w_q[k_idx]);
          k_d       = k_q + 1'b1;
        end else if (den_acc_q == '0) begin
          y_d      = DEFAULT_Y;
          zero_w_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          div_start = 1'b1;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        if (div_done) begin
          y_d      = $signed(apply_sign(div_quot, num_acc_q[NUM_W-1]));
          zero_w_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      num_acc_q <= '0;
      den_acc_q <= '0;
      y_q       <= '0;
      zero_w_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      num_acc_q <= num_acc_d;
      den_acc_q <= den_acc_d;
      y_q       <= y_d;
      zero_w_q  <= zero_w_d;
    end
  end

  // Operands are captured on acceptance so later input changes cannot disturb the result.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N_RULES; i++) begin
        w_q[i] <= w_in[i];
        c_q[i] <= c_all[i*C_W +: C_W];
      end
    end
  end

  defuzz_serial_div div_serial_u (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (num_mag),
    .divisor_i  (den_acc_q),
    .quotient_o (div_quot),
    .done_o     (div_done)
  );

  assign y         = y_q;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign zero_w    = zero_w_q;

endmodule

// File: tb/tb_defuzz_serial.sv
// Self-checking bench for defuzz_serial: directed cases plus randomized weights/singletons
// compared against a plain-arithmetic weighted-average model.
module tb_defuzz_serial;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic [143:0]       c_all;
  logic signed [15:0] y;
  logic               out_valid, busy, zero_w;

  int checks = 0;
  int errors = 0;

  logic [15:0]        wv [9];
  logic signed [15:0] cv [9];

  localparam logic signed [15:0] DEF_Y = -16'sd5;

  always #5 clk = ~clk;

  defuzz_serial #(.DEFAULT_Y(DEF_Y)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .w00       (w00),
    .w01       (w01),
    .w02       (w02),
    .w10       (w10),
    .w11       (w11),
    .w12       (w12),
    .w20       (w20),
    .w21       (w21),
    .w22       (w22),
    .c_all     (c_all),
    .y         (y),
    .out_valid (out_valid),
    .busy      (busy),
    .zero_w    (zero_w)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Weighted average from the defining formula; SV integer division truncates toward zero.
  function automatic void model(output logic signed [31:0] ey, output logic ez);
    longint num = 0;
    longint den = 0;
    for (int i = 0; i < 9; i++) begin
      num += longint'(wv[i]) * longint'(cv[i]);
      den += longint'(wv[i]);
    end
    if (den == 0) begin
      ey = DEF_Y;
      ez = 1'b1;
    end else begin
      ey = 32'(num / den);
      ez = 1'b0;
    end
  endfunction

  task automatic clear_vec();
    for (int i = 0; i < 9; i++) begin
      wv[i] = '0;
      cv[i] = '0;
    end
  endtask

  task automatic drive_inputs();
    {w00, w01, w02, w10, w11, w12, w20, w21, w22} =
      {wv[0], wv[1], wv[2], wv[3], wv[4], wv[5], wv[6], wv[7], wv[8]};
    for (int i = 0; i < 9; i++) c_all[16*i +: 16] = cv[i];
  endtask

  task automatic scramble_inputs();
    w00 = 16'($urandom); w01 = 16'($urandom); w02 = 16'($urandom);
    w10 = 16'($urandom); w11 = 16'($urandom); w12 = 16'($urandom);
    w20 = 16'($urandom); w21 = 16'($urandom); w22 = 16'($urandom);
    for (int i = 0; i < 9; i++) c_all[16*i +: 16] = 16'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after DONE.
  task automatic run_op(input string tag);
    logic signed [31:0] ey;
    logic               ez;
    int                 lat;
    model(ey, ez);
    drive_inputs();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    check($sformatf("%s.busy_run", tag), busy, 1);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check($sformatf("%s.latency", tag), lat, ez ? 10 : 45);
    check($sformatf("%s.y", tag), y, ey);
    check($sformatf("%s.zero_w", tag), zero_w, ez);
    check($sformatf("%s.busy_done", tag), busy, 1);
    @(posedge clk); @(negedge clk);
    check($sformatf("%s.valid_pulse", tag), out_valid, 0);
    check($sformatf("%s.idle", tag), busy, 0);
  endtask

  initial begin
    int pulses;
    int first;
    logic signed [31:0] ey;
    logic               ez;

    rst   = 1'b1;
    start = 1'b0;
    clear_vec();
    drive_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.y", y, 0);
    check("reset.out_valid", out_valid, 0);
    check("reset.busy", busy, 0);
    check("reset.zero_w", zero_w, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    // All-zero weights take the short path to DEFAULT_Y.
    clear_vec();
    run_op("zero_w");

    clear_vec(); wv[4] = 16'hFFFF; cv[4] = 16'sd1000;
    run_op("single");

    clear_vec(); wv[0] = 16'h8000; wv[8] = 16'h8000; cv[0] = -16'sd1000; cv[8] = 16'sd3000;
    run_op("pair_pos");
    cv[0] = 16'sd1000; cv[8] = -16'sd3000;
    run_op("pair_neg");

    clear_vec(); wv[0] = 16'd1; wv[1] = 16'd2; cv[1] = -16'sd1;
    run_op("trunc_m2_3");
    cv[1] = 16'sd1;
    run_op("trunc_p2_3");
    wv[1] = 16'd3; cv[1] = -16'sd1;
    run_op("trunc_m3_4");
    cv[1] = -16'sd2;
    run_op("trunc_m6_4");

    for (int i = 0; i < 9; i++) begin wv[i] = 16'hFFFF; cv[i] = -16'sd32768; end
    run_op("ext_min");
    for (int i = 0; i < 9; i++) cv[i] = 16'sd32767;
    run_op("ext_max");

    // Randomized mix of zero, tiny, full-range and saturated weights.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 9; i++) begin
        case ($urandom_range(0, 3))
          0:       wv[i] = 16'd0;
          1:       wv[i] = 16'($urandom_range(0, 7));
          2:       wv[i] = 16'($urandom);
          default: wv[i] = 16'hFFFF;
        endcase
        cv[i] = 16'($urandom);
      end
      if (t == 5) for (int i = 0; i < 9; i++) wv[i] = 16'd0;
      run_op($sformatf("rand%0d", t));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // Start pulses at E+5 and during DONE must be ignored.
    clear_vec(); wv[2] = 16'd300; wv[6] = 16'd100; cv[2] = 16'sd400; cv[6] = -16'sd800;
    model(ey, ez);
    drive_inputs();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    pulses = 0;
    first  = 0;
    for (int n = 1; n <= 110; n++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (n == 4) start = 1'b1;
      if (out_valid) begin
        pulses++;
        if (first == 0) begin
          first = n;
          check("ignore.y", y, ey);
        end
        start = 1'b1;
      end
    end
    start = 1'b0;
    check("ignore.pulses", pulses, 1);
    check("ignore.latency", first, 45);
    check("ignore.idle", busy, 0);

    // Reset at E+20 aborts without a result strobe.
    clear_vec(); wv[4] = 16'd100; cv[4] = 16'sd77;
    drive_inputs();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (19) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("abort.busy", busy, 0);
    check("abort.out_valid", out_valid, 0);
    check("abort.y", y, 0);
    check("abort.zero_w", zero_w, 0);
    pulses = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) pulses++;
    end
    check("abort.no_valid", pulses, 0);

    // Back-to-back: each run_op starts in the first idle cycle after the previous DONE.
    clear_vec(); wv[3] = 16'd5; cv[3] = 16'sd123;
    run_op("b2b_a");
    wv[5] = 16'd7; cv[5] = -16'sd456;
    run_op("b2b_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/defuzz_serial.md
Name: defuzz_serial

Overview:
- Consumes the nine rule-firing weights w00..w22 from the 3x3 min-rule grid and produces one crisp signed output.
- Method: zero-order Sugeno weighted average, y = sum(w_k*c_k) / sum(w_k).
- One multiply-accumulate per cycle, then a serial restoring divide.
- Sits between the rule stage and the actuator/output register.

Parameters:
- DEFAULT_Y, 16'sd0: crisp value emitted when all weights are zero.
- N_RULES, 9: rule count; fixed, listed for documentation only.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- w00,w01,w02,w10,w11,w12,w20,w21,w22  in  16 each  unsigned rule weights, same order as rule grid (T index, dT index)
- c_all  in  144  packed signed singletons; rule k=3*i+j at bits [16k+15:16k]
- y  out  16  signed crisp result
- out_valid  out  1  one-cycle result strobe
- busy  out  1  high whenever FSM not IDLE
- zero_w  out  1  result came from the all-zero-weight path; valid with out_valid

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; y=0, out_valid=0, busy=0, zero_w=0; accumulators cleared. Reset mid-operation aborts with no out_valid and returns to IDLE.
- IDLE:
  - start=1 at edge E latches all nine weights and c_all into local registers.
  - Clears num_acc (36-bit signed) and den_acc (20-bit unsigned).
  - Rule index set to 0; goes to ACCUM.
- ACCUM, 9 cycles, edges E+1..E+9:
  - num_acc += {1'b0,w_k} * c_k (signed 33-bit product); den_acc += w_k; k increments.
  - After k=8 the next state is evaluated on the updated sums: den==0 -> DONE with y=DEFAULT_Y, zero_w=1; otherwise -> DIV.
- DIV, 35 cycles:
  - Restoring division of |num_acc| (35 magnitude bits) by den_acc, one quotient bit per cycle, MSB first.
  - Quotient truncates toward zero.
  - Sign is applied afterward: negative iff num_acc<0.
  - Result always lies within [min c_k, max c_k], so 16-bit signed never overflows. Magnitude 32768 is legal only for negative results.
- DONE, 1 cycle: out_valid=1, busy=1, y and zero_w updated. Next edge -> IDLE.
- Latency, counted from the accepting edge E:
  - out_valid is high in the cycle after edge E+45 (nonzero path).
  - out_valid is high in the cycle after edge E+10 (zero path).
- Holding and start rules:
  - y and zero_w hold until the next DONE.
  - out_valid is never high for more than one cycle.
  - start while busy=1 (including DONE) is ignored, not queued.
  - start in the first IDLE cycle after DONE is accepted, giving back-to-back throughput of 1 result per 47 cycles.
- Input changes on w*/c_all after acceptance have no effect on the current result.

Decomposition:
- Shared header fuzzy_defs.vh holds:
  - N_RULES=9, W_W=16, C_W=16, NUM_W=36, DEN_W=20, DIV_STEPS=35.
  - FSM encodings S_IDLE, S_ACCUM, S_DIV, S_DONE.
- One natural sub-module, div_serial_u: unsigned restoring divider with start/done and 35-step count.
  - Owned by defuzz_serial; sign handling stays in the parent.

Test Plan:
- All weights 0, DEFAULT_Y=-5, start -> out_valid at E+10, y=-5, zero_w=1.
- w11=16'hFFFF, others 0, c11=1000 -> y=1000, zero_w=0, out_valid at E+45.
- w00=w22=16'h8000, c00=-1000, c22=3000, others w=0 -> y=1000. Swap signs of c00/c22 -> y=-1000.
- Truncation: w00=1, w01=2, c00=0, c01=-1 -> y=0 (-2/3 truncated). With c01=+1 -> y=0. With w01=3, c01=-1 -> y=0 (-3/4). With w01=3, c01=-2 -> y=-1 (-6/4).
- Extremes: all w=16'hFFFF, all c=-32768 -> y=-32768. Repeat with all c=32767 -> y=32767.
- Control: pulse start again at E+5 and inside DONE -> ignored, single out_valid. Assert rst at E+20 -> no out_valid, busy=0 next cycle, y=0. Back-to-back start right after DONE -> second result at its own E+45.
